// File: rtl/tod_pkg.sv
// Shared types and 32.32 time format constants for the time-of-day accumulator.
package tod_pkg;
  localparam int TOD_W    = 64;
  localparam int TOD_FRAC = 32;

  typedef enum logic {IDLE, WAIT} state_e;

  typedef enum logic [1:0] {OP_NONE, OP_TICK, OP_ADJ} op_e;
endpackage

// File: rtl/tod_adder_ctl_if.sv
// Request/status bundle between the tick/PPS logic and the time-of-day controller.
interface tod_adder_ctl_if;
  import tod_pkg::*;

  logic             i_tick;
  logic             i_step_wr;
  logic [TOD_W-1:0] i_step;
  logic             i_set_stb;
  logic [TOD_W-1:0] i_set_val;
  logic             i_adj_stb;
  logic [TOD_W-1:0] i_adj_val;
  logic             o_adj_busy;
  logic             o_adj_done;
  logic [TOD_W-1:0] o_tod;
  logic             o_pps;
  logic             o_overrun;

  modport master (
    output i_tick, i_step_wr, i_step, i_set_stb, i_set_val, i_adj_stb, i_adj_val,
    input  o_adj_busy, o_adj_done, o_tod, o_pps, o_overrun
  );

  modport slave (
    input  i_tick, i_step_wr, i_step, i_set_stb, i_set_val, i_adj_stb, i_adj_val,
    output o_adj_busy, o_adj_done, o_tod, o_pps, o_overrun
  );
endinterface

// File: rtl/tod_adder_ctl_bigadd.sv
// bigadd: wide adder followed by NCLOCKS register stages; i_sync travels with the sum.
module bigadd #(
  parameter int NCLOCKS = 1,
  parameter int DATA_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_sync,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_sync,
  output logic [DATA_W-1:0] o_sum
);
  generate
    if (NCLOCKS == 0) begin : g_comb
      assign o_sum  = i_a + i_b;
      assign o_sync = i_sync;
    end else begin : g_pipe
      logic [DATA_W-1:0] sum_q [NCLOCKS];
      logic [NCLOCKS-1:0] sync_q;

      always_ff @(posedge clk) begin
        sum_q[0] <= i_a + i_b;
        for (int i = 1; i < NCLOCKS; i++) sum_q[i] <= sum_q[i-1];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= i_sync;
          for (int i = 1; i < NCLOCKS; i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign o_sum  = sum_q[NCLOCKS-1];
      assign o_sync = sync_q[NCLOCKS-1];
    end
  endgenerate
endmodule

// File: rtl/tod_adder_ctl.sv
// tod_adder_ctl: 32.32 time-of-day register updated through one shared pipelined adder.
// Define TOD_ADJ_EN to build the signed adjust path (holding register and o_adj_* outputs).
module tod_adder_ctl
  import tod_pkg::*;
#(
  parameter int               LAT          = 1,
  parameter int               TW           = 3,
  parameter logic [TOD_W-1:0] INITIAL_STEP = 64'h0000_0000_2AF3_1DC4
) (
  input logic            i_clk,
  input logic            i_reset,
  tod_adder_ctl_if.slave bus
);
  localparam logic [TW-1:0] PEND_MAX = '1;

  state_e           state_q;
  op_e              op_q;
  logic [1:0]       cnt_q;
  logic             abort_q;
  logic [TW-1:0]    pend_q, pend_d;
  logic             ovr_q, ovr_d;
  logic [TOD_W-1:0] tod_q, step_q;
  logic             pps_q;

  logic             can_issue, issue_tick, issue_adj, issue;
  op_e              issue_op, wb_op;
  logic [TOD_W-1:0] add_b, add_sum;
  logic             add_sync, wb_fire;

  assign can_issue  = (state_q == IDLE) && !bus.i_set_stb;
  assign issue_tick = can_issue && (pend_q != '0);

`ifdef TOD_ADJ_EN
  logic             busy_q, done_q;
  logic [TOD_W-1:0] adj_q;

  assign issue_adj = can_issue && (pend_q == '0) && busy_q;
  assign add_b     = issue_adj ? adj_q : step_q;
`else
  logic unused_adj;

  assign unused_adj = ^{bus.i_adj_stb, bus.i_adj_val};
  assign issue_adj  = 1'b0;
  assign add_b      = step_q;
`endif

  assign issue    = issue_tick || issue_adj;
  assign issue_op = issue_tick ? OP_TICK : (issue_adj ? OP_ADJ : OP_NONE);
  assign wb_op    = (LAT == 0) ? issue_op : op_q;

  bigadd #(.NCLOCKS(LAT), .DATA_W(TOD_W)) u_add (
    .clk    (i_clk),
    .rst    (i_reset),
    .i_sync (issue),
    .i_a    (tod_q),
    .i_b    (add_b),
    .o_sync (add_sync),
    .o_sum  (add_sum)
  );

  // A set in the same cycle as the sum emerges always wins; aborted sums are dropped.
  assign wb_fire = add_sync && !bus.i_set_stb &&
                   ((LAT == 0) || ((state_q == WAIT) && (cnt_q == 2'd0) && !abort_q));

  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    if (bus.i_set_stb) begin
      pend_d = {{(TW-1){1'b0}}, bus.i_tick};
    end else if (bus.i_tick && !issue_tick) begin
      if (pend_q == PEND_MAX) ovr_d = 1'b1;
      else                    pend_d = pend_q + 1'b1;
    end else if (!bus.i_tick && issue_tick) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      pend_q  <= '0;
      ovr_q   <= 1'b0;
      tod_q   <= '0;
      step_q  <= INITIAL_STEP;
      pps_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      pps_q  <= 1'b0;
      if (bus.i_step_wr) step_q <= bus.i_step;
      case (state_q)
        IDLE: if (issue && (LAT != 0)) begin
          state_q <= WAIT;
          cnt_q   <= 2'(LAT - 1);
          abort_q <= 1'b0;
        end
        WAIT: begin
          if (bus.i_set_stb) abort_q <= 1'b1;
          if (cnt_q == 2'd0) state_q <= IDLE;
          else               cnt_q   <= cnt_q - 2'd1;
        end
      endcase
      if (bus.i_set_stb) begin
        tod_q <= bus.i_set_val;
      end else if (wb_fire) begin
        tod_q <= add_sum;
        pps_q <= (wb_op == OP_TICK) &&
                 (add_sum[TOD_W-1:TOD_FRAC] != tod_q[TOD_W-1:TOD_FRAC]);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (issue) op_q <= issue_op;
  end

`ifdef TOD_ADJ_EN
  // The held offset survives a set and is simply reissued against the new time.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= wb_fire && (wb_op == OP_ADJ);
      if (wb_fire && (wb_op == OP_ADJ)) busy_q <= 1'b0;
      else if (!busy_q && bus.i_adj_stb) busy_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!busy_q && bus.i_adj_stb) adj_q <= bus.i_adj_val;
  end

  assign bus.o_adj_busy = busy_q;
  assign bus.o_adj_done = done_q;
`else
  assign bus.o_adj_busy = 1'b0;
  assign bus.o_adj_done = 1'b0;
`endif

  assign bus.o_tod     = tod_q;
  assign bus.o_pps     = pps_q;
  assign bus.o_overrun = ovr_q;
endmodule

// File: tb/tb_tod_adder_ctl.sv
// Directed bench for tod_adder_ctl with LAT=2, TW=3; adjust expectations follow TOD_ADJ_EN.
module tb_tod_adder_ctl;
  localparam logic [63:0] INIT_STEP = 64'h0000_0000_2AF3_1DC4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errs   = 0;

  tod_adder_ctl_if bus();

  tod_adder_ctl #(.LAT(2), .TW(3), .INITIAL_STEP(INIT_STEP)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int          cyc      = 0;
  int          wb_cnt   = 0;
  int          pps_cnt  = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;
  int          wb_t [256];
  logic [63:0] prev_tod = '0;
  logic [63:0] pps_tod  = '0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (bus.o_tod !== prev_tod) begin
      if (wb_cnt < 256) wb_t[wb_cnt] = cyc;
      wb_cnt++;
      prev_tod = bus.o_tod;
    end
    if (bus.o_pps === 1'b1) begin
      pps_cnt++;
      pps_tod = bus.o_tod;
    end
    if (bus.o_adj_done === 1'b1) done_cnt++;
    if (bus.o_adj_busy === 1'b1) busy_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_tod(input logic [63:0] v);
    @(negedge clk);
    bus.i_set_stb = 1'b1;
    bus.i_set_val = v;
    @(negedge clk);
    bus.i_set_stb = 1'b0;
  endtask

  task automatic write_step(input logic [63:0] v);
    @(negedge clk);
    bus.i_step_wr = 1'b1;
    bus.i_step    = v;
    @(negedge clk);
    bus.i_step_wr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.o_tod !== 64'h0) begin errs++; $display("FAIL reset_tod: got %h expected %h", bus.o_tod, 64'h0); end
    checks++; if (bus.o_pps !== 1'b0) begin errs++; $display("FAIL reset_pps: got %b expected 0", bus.o_pps); end
    checks++; if (bus.o_overrun !== 1'b0) begin errs++; $display("FAIL reset_overrun: got %b expected 0", bus.o_overrun); end
    checks++; if (bus.o_adj_busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", bus.o_adj_busy); end
    checks++; if (bus.o_adj_done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b expected 0", bus.o_adj_done); end
    rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_single_tick;
    int p0;
    p0 = pps_cnt;
    @(negedge clk);
    bus.i_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_tick = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (bus.o_tod !== 64'h0) begin errs++; $display("FAIL tick_early: got %h expected %h", bus.o_tod, 64'h0); end
    @(posedge clk);
    #1;
    checks++; if (bus.o_tod !== INIT_STEP) begin errs++; $display("FAIL tick_result: got %h expected %h", bus.o_tod, INIT_STEP); end
    @(negedge clk);
    checks++; if (pps_cnt !== p0) begin errs++; $display("FAIL tick_pps: got %0d pulses expected 0", pps_cnt - p0); end
  endtask

  task automatic test_pps;
    int p0;
    write_step(64'h0000_0000_8000_0000);
    set_tod(64'h0);
    p0 = pps_cnt;
    @(negedge clk); bus.i_tick = 1'b1;
    @(negedge clk); bus.i_tick = 1'b1;
    @(negedge clk); bus.i_tick = 1'b0;
    idle_cycles(3);
    // Second tick is in flight here; a new step must not leak into its sum.
    bus.i_step_wr = 1'b1;
    bus.i_step    = 64'h1;
    @(negedge clk);
    bus.i_step_wr = 1'b0;
    idle_cycles(6);
    checks++; if (bus.o_tod !== 64'h0000_0001_0000_0000) begin errs++; $display("FAIL pps_tod: got %h expected %h", bus.o_tod, 64'h0000_0001_0000_0000); end
    checks++; if (pps_cnt - p0 !== 1) begin errs++; $display("FAIL pps_count: got %0d expected 1", pps_cnt - p0); end
    checks++; if (pps_tod !== 64'h0000_0001_0000_0000) begin errs++; $display("FAIL pps_when: got %h expected %h", pps_tod, 64'h0000_0001_0000_0000); end
  endtask

  task automatic test_back_to_back;
    int w0;
    write_step(64'h100);
    set_tod(64'h0);
    idle_cycles(2);
    w0 = wb_cnt;
    @(negedge clk);
    bus.i_tick = 1'b1;
    repeat (8) @(negedge clk);
    bus.i_tick = 1'b0;
    idle_cycles(30);
    checks++; if (wb_cnt - w0 !== 8) begin errs++; $display("FAIL b2b_count: got %0d expected 8", wb_cnt - w0); end
    checks++; if (bus.o_tod !== 64'h800) begin errs++; $display("FAIL b2b_tod: got %h expected %h", bus.o_tod, 64'h800); end
    checks++; if (bus.o_overrun !== 1'b0) begin errs++; $display("FAIL b2b_overrun: got %b expected 0", bus.o_overrun); end
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (wb_t[w0+i] - wb_t[w0+i-1] !== 3) begin
        errs++;
        $display("FAIL b2b_spacing%0d: got %0d expected 3", i, wb_t[w0+i] - wb_t[w0+i-1]);
      end
    end
  endtask

  task automatic test_overrun;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      bus.i_tick = 1'b1;
      @(posedge clk);
      #1;
      if (n == 11) begin
        checks++; if (bus.o_overrun !== 1'b0) begin errs++; $display("FAIL ovr_before: got %b expected 0", bus.o_overrun); end
      end
      if (n == 12) begin
        checks++; if (bus.o_overrun !== 1'b1) begin errs++; $display("FAIL ovr_set: got %b expected 1", bus.o_overrun); end
      end
    end
    @(negedge clk);
    bus.i_tick = 1'b0;
    idle_cycles(40);
    checks++; if (bus.o_tod !== 64'h1500) begin errs++; $display("FAIL ovr_tod: got %h expected %h", bus.o_tod, 64'h1500); end
    checks++; if (bus.o_overrun !== 1'b1) begin errs++; $display("FAIL ovr_sticky: got %b expected 1", bus.o_overrun); end
  endtask

  task automatic test_adjust;
    int d0;
    int b0;
    set_tod(64'h10);
    idle_cycles(1);
    d0 = done_cnt;
    b0 = busy_cnt;
    @(negedge clk);
    bus.i_adj_stb = 1'b1;
    bus.i_adj_val = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    bus.i_adj_val = 64'h100;
`ifdef TOD_ADJ_EN
    checks++; if (bus.o_adj_busy !== 1'b1) begin errs++; $display("FAIL adj_busy_rise: got %b expected 1", bus.o_adj_busy); end
`else
    checks++; if (bus.o_adj_busy !== 1'b0) begin errs++; $display("FAIL adj_busy_off: got %b expected 0", bus.o_adj_busy); end
`endif
    @(negedge clk);
    bus.i_adj_stb = 1'b0;
    idle_cycles(10);
`ifdef TOD_ADJ_EN
    checks++; if (bus.o_tod !== 64'h0F) begin errs++; $display("FAIL adj_tod: got %h expected %h", bus.o_tod, 64'h0F); end
    checks++; if (done_cnt - d0 !== 1) begin errs++; $display("FAIL adj_done: got %0d expected 1", done_cnt - d0); end
    checks++; if (bus.o_adj_busy !== 1'b0) begin errs++; $display("FAIL adj_busy_fall: got %b expected 0", bus.o_adj_busy); end
`else
    checks++; if (bus.o_tod !== 64'h10) begin errs++; $display("FAIL adj_tod_off: got %h expected %h", bus.o_tod, 64'h10); end
    checks++; if (done_cnt - d0 !== 0) begin errs++; $display("FAIL adj_done_off: got %0d expected 0", done_cnt - d0); end
    checks++; if (busy_cnt - b0 !== 0) begin errs++; $display("FAIL adj_busy_seen: got %0d expected 0", busy_cnt - b0); end
`endif
  endtask

  task automatic test_set_abort;
    int p0;
    int d0;
    logic [63:0] exp_tod;
    int          exp_done;
`ifdef TOD_ADJ_EN
    exp_tod  = 64'h0000_0005_0000_0003;
    exp_done = 1;
`else
    exp_tod  = 64'h0000_0005_0000_0000;
    exp_done = 0;
`endif
    write_step(64'h0000_0001_0000_0000);
    set_tod(64'h0);
    idle_cycles(1);
    p0 = pps_cnt;
    d0 = done_cnt;
    @(negedge clk);
    bus.i_tick    = 1'b1;
    bus.i_adj_stb = 1'b1;
    bus.i_adj_val = 64'h3;
    @(negedge clk);
    bus.i_tick    = 1'b0;
    bus.i_adj_stb = 1'b0;
    @(negedge clk);
    bus.i_set_stb = 1'b1;
    bus.i_set_val = 64'h0000_0005_0000_0000;
    @(negedge clk);
    bus.i_set_stb = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.o_tod !== 64'h0000_0005_0000_0000) begin errs++; $display("FAIL set_discard: got %h expected %h", bus.o_tod, 64'h0000_0005_0000_0000); end
    idle_cycles(8);
    checks++; if (bus.o_tod !== exp_tod) begin errs++; $display("FAIL set_final: got %h expected %h", bus.o_tod, exp_tod); end
    checks++; if (pps_cnt - p0 !== 0) begin errs++; $display("FAIL set_pps: got %0d expected 0", pps_cnt - p0); end
    checks++; if (done_cnt - d0 !== exp_done) begin errs++; $display("FAIL set_done: got %0d expected %0d", done_cnt - d0, exp_done); end
  endtask

  task automatic test_reset_flush;
    @(negedge clk); bus.i_tick = 1'b1;
    @(negedge clk); bus.i_tick = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (bus.o_tod !== 64'h0) begin errs++; $display("FAIL flush_reset: got %h expected %h", bus.o_tod, 64'h0); end
    idle_cycles(5);
    checks++; if (bus.o_tod !== 64'h0) begin errs++; $display("FAIL flush_discard: got %h expected %h", bus.o_tod, 64'h0); end
    checks++; if (bus.o_overrun !== 1'b0) begin errs++; $display("FAIL flush_overrun: got %b expected 0", bus.o_overrun); end
    @(negedge clk); bus.i_tick = 1'b1;
    @(negedge clk); bus.i_tick = 1'b0;
    idle_cycles(6);
    checks++; if (bus.o_tod !== INIT_STEP) begin errs++; $display("FAIL flush_step: got %h expected %h", bus.o_tod, INIT_STEP); end
  endtask

  initial begin
    rst           = 1'b1;
    bus.i_tick    = 1'b0;
    bus.i_step_wr = 1'b0;
    bus.i_step    = '0;
    bus.i_set_stb = 1'b0;
    bus.i_set_val = '0;
    bus.i_adj_stb = 1'b0;
    bus.i_adj_val = '0;
    test_reset;
    test_single_tick;
    test_pps;
    test_back_to_back;
    test_overrun;
    test_adjust;
    test_set_abort;
    test_reset_flush;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
